// File: rtl/spi_pix_pkg.sv
// Shared types and constants for the SPI pixel deserializer: output FSM
// encoding, pixel/word widths and the default frame size.
package spi_pix_pkg;

    localparam int PIX_W                 = 8;
    localparam int WORD_W                = 9;
    localparam int CNT_W                 = 11;
    localparam int PIX_PER_FRAME_DEFAULT = 1200;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SETUP = 4'b0010,
        ST_HIGH  = 4'b0100,
        ST_LOW   = 4'b1000
    } out_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, cleared to 0 on reset.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], din};
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/spi_pixel_deser.sv
// SPI (mode 0, MSB first) to pixel-strobe front end: assembles bytes per
// cs_n-framed frame, tags the first pixel, and emits Data with a slow clk_SPI.
module spi_pixel_deser
    import spi_pix_pkg::*;
#(
    parameter int PIX_PER_FRAME = PIX_PER_FRAME_DEFAULT,
    parameter int STROBE_HIGH   = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    input  logic              clr_flags,
    output logic [WORD_W-1:0] Data,
    output logic              clk_SPI,
    output logic [CNT_W-1:0]  pixel_count,
    output logic              frame_short,
    output logic              frame_long,
    output logic              overflow
);

    localparam int               TMR_W      = (STROBE_HIGH > 1) ? $clog2(STROBE_HIGH) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(STROBE_HIGH - 1);
    localparam logic [CNT_W-1:0] PIX_LIMIT  = CNT_W'(PIX_PER_FRAME);

    logic sclk_s, mosi_s, cs_n_s, sclk_d, cs_n_d;
    logic sclk_rise, cs_fall, cs_rise, bit_evt, byte_evt;
    logic frame_active, sof_pending, frame_full;
    logic [2:0]            bit_cnt;
    logic [PIX_W-2:0]      shift_q;
    logic [CNT_W-1:0]      acc_cnt, acc_after;
    logic [WORD_W-1:0]     byte_word, hold_word, load_word;
    logic hold_full, hold_busy, accept, pix_avail, load;
    out_state_t            state, state_next;
    logic [TMR_W-1:0]      tmr;
    logic                  tmr_last, clk_SPI_next;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.CLK(CLK), .reset(reset), .din(sclk), .dout(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.CLK(CLK), .reset(reset), .din(mosi), .dout(mosi_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs_n (.CLK(CLK), .reset(reset), .din(cs_n), .dout(cs_n_s));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sclk_d <= 1'b0;
            cs_n_d <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            cs_n_d <= cs_n_s;
        end
    end

    // Only a real cs_n fall opens a frame, so traffic already in flight at reset release is ignored.
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_fall   = cs_n_d & ~cs_n_s;
    assign cs_rise   = ~cs_n_d & cs_n_s;
    assign bit_evt   = frame_active & sclk_rise;
    assign byte_evt  = bit_evt & (bit_cnt == 3'd7);
    assign byte_word = {sof_pending, shift_q, mosi_s};

    assign frame_full = (acc_cnt >= PIX_LIMIT);
    assign pix_avail  = hold_full | (byte_evt & ~frame_full);
    assign hold_busy  = hold_full & ~load;
    assign accept     = byte_evt & ~frame_full & ~hold_busy;
    assign load_word  = hold_full ? hold_word : byte_word;
    assign acc_after  = acc_cnt + {{(CNT_W-1){1'b0}}, accept};
    assign tmr_last   = (tmr == TMR_LAST);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            frame_active <= 1'b0;
            sof_pending  <= 1'b0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            acc_cnt      <= '0;
        end else begin
            if (cs_fall)      frame_active <= 1'b1;
            else if (cs_rise) frame_active <= 1'b0;

            if (cs_fall)       sof_pending <= 1'b1;
            else if (byte_evt) sof_pending <= 1'b0;

            if (cs_fall || cs_rise) bit_cnt <= '0;
            else if (bit_evt)       bit_cnt <= bit_cnt + 3'd1;

            if (bit_evt) shift_q <= {shift_q[PIX_W-3:0], mosi_s};

            if (cs_fall)     acc_cnt <= '0;
            else if (accept) acc_cnt <= acc_cnt + 1'b1;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pix_avail) begin
                    load       = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: state_next = ST_HIGH;
            ST_HIGH:  if (tmr_last) state_next = ST_LOW;
            ST_LOW: begin
                if (tmr_last) begin
                    if (pix_avail) begin
                        load       = 1'b1;
                        state_next = ST_SETUP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        clk_SPI_next = (state_next == ST_HIGH);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            tmr     <= '0;
            clk_SPI <= 1'b0;
        end else begin
            state   <= state_next;
            clk_SPI <= clk_SPI_next;
            if (state_next != state) tmr <= '0;
            else                     tmr <= tmr + 1'b1;
        end
    end

    // A byte arriving while the held one is handed to Data in the same cycle still finds room.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            hold_full   <= 1'b0;
            hold_word   <= '0;
            Data        <= '0;
            pixel_count <= '0;
            frame_short <= 1'b0;
            frame_long  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (accept && (hold_full || !load)) begin
                hold_word <= byte_word;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) Data <= load_word;

            if (cs_fall)                pixel_count <= '0;
            else if (state == ST_SETUP) pixel_count <= pixel_count + 1'b1;

            frame_short <= (frame_active & cs_rise & (acc_after < PIX_LIMIT)) | (frame_short & ~clr_flags);
            frame_long  <= (byte_evt & frame_full) | (frame_long & ~clr_flags);
            overflow    <= (byte_evt & ~frame_full & hold_busy) | (overflow & ~clr_flags);
        end
    end

endmodule
